// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-bit clock counter, cleared by the FSM on entries and samples.
import uart_pkg::*;

module uart_bit_timer #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (enable)
            r_count <= r_count + CNT_W'(1);
    end

    assign count = r_count;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with start-bit glitch rejection,
// framing-error and overrun pulses, and a valid/ready output register.
import uart_pkg::*;

module uart_rx #(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxLevel,
    input  logic                 rxFall,
    input  logic                 rxReady,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    rx_state_t            r_state;
    rx_state_t            w_next;
    logic [CNT_W-1:0]     w_count;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_mid;
    logic                 w_last;
    logic                 w_last_bit;
    logic                 w_busy;
    logic                 w_data_sample;
    logic                 w_stop_sample;
    logic                 w_deliver;
    logic                 w_clear;

    assign w_mid      = w_count == CNT_W'(CLKS_PER_BIT / 2 - 1);
    assign w_last     = w_count == CNT_W'(CLKS_PER_BIT - 1);
    assign w_last_bit = r_bit_idx == IDX_W'(DATA_BITS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = rxFall ? START : IDLE;
            START:   w_next = w_mid ? (rxLevel ? IDLE : DATA) : START;
            DATA:    w_next = (w_last && w_last_bit) ? STOP : DATA;
            STOP:    w_next = w_last ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy        = r_state != IDLE;
        w_data_sample = (r_state == DATA) && w_last;
        w_stop_sample = (r_state == STOP) && w_last;
    end

    // Restart timing on every state change so each phase measures from its own entry.
    assign w_clear   = (w_next != r_state) || w_data_sample;
    assign w_deliver = w_stop_sample && rxLevel;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .enable (w_busy),
        .count  (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_bit_idx <= (r_state != DATA) ? '0 : (w_data_sample ? r_bit_idx + IDX_W'(1) : r_bit_idx);
            if (w_data_sample)
                r_shift <= {rxLevel, r_shift[DATA_BITS-1:1]};
        end
    end

    // A pending unconsumed word wins over a new one; a word consumed this cycle is replaced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_sample && !rxLevel;
            r_overrun   <= w_deliver && r_valid && !rxReady;
            if (w_deliver) begin
                r_valid <= 1'b1;
                if (!(r_valid && !rxReady))
                    r_data <= r_shift;
            end else if (r_valid && rxReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rxData   = r_data;
    assign rxValid  = r_valid;
    assign frameErr = r_frame_err;
    assign overrun  = r_overrun;
    assign busy     = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame-level checks of uart_rx at 16 clocks/bit, 8 data bits.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxLevel = 1'b1;
    logic       rxFall = 1'b0;
    logic       rxReady = 1'b0;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    logic       prev_lvl = 1'b1;

    int         n_vrise = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    logic       pv = 1'b0;
    logic [7:0] cap0 = 8'h00;
    logic [7:0] cap1 = 8'h00;
    int         b_vrise, b_ferr, b_ovr;

    uart_rx #(
        .DATA_BITS    (8),
        .CLKS_PER_BIT (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxLevel  (rxLevel),
        .rxFall   (rxFall),
        .rxReady  (rxReady),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .frameErr (frameErr),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxValid && !pv) begin
            n_vrise++;
            cap0 = cap1;
            cap1 = rxData;
        end
        if (frameErr) n_ferr++;
        if (overrun) n_ovr++;
        pv = rxValid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic lvl);
        rxFall   = prev_lvl && !lvl;
        rxLevel  = lvl;
        prev_lvl = lvl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic lvl_at(input logic [7:0] d, input logic s, input int i);
        return (i < 16) ? 1'b0 : (i < 144) ? d[(i - 16) / 16] : s;
    endfunction

    task automatic send(input logic [7:0] d, input logic s, input int n);
        for (int i = 0; i < n; i++) step(lvl_at(d, s, i));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic snap;
        b_vrise = n_vrise;
        b_ferr  = n_ferr;
        b_ovr   = n_ovr;
    endtask

    initial begin
        idle(3);
        check("rst_data", rxData, 8'h00);
        check("rst_valid", rxValid, 0);
        check("rst_ferr", frameErr, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        rxReady = 1'b1;
        idle(4);

        send(8'hA5, 1'b1, 152);
        check("a5_pre_valid", rxValid, 0);
        step(1'b1);
        check("a5_valid", rxValid, 1);
        check("a5_data", rxData, 8'hA5);
        check("a5_ferr", frameErr, 0);
        check("a5_ovr", overrun, 0);
        step(1'b1);
        check("a5_valid_drop", rxValid, 0);
        idle(6);
        check("a5_idle", busy, 0);

        snap();
        step(1'b0);
        check("gl_busy_hi", busy, 1);
        step(1'b0); step(1'b0); step(1'b0);
        idle(4);
        check("gl_busy_7", busy, 1);
        idle(1);
        check("gl_busy_lo", busy, 0);
        idle(4);
        check("gl_no_valid", n_vrise - b_vrise, 0);
        check("gl_no_ferr", n_ferr - b_ferr, 0);

        snap();
        send(8'h3C, 1'b0, 152);
        step(1'b0);
        check("fe_pulse", frameErr, 1);
        check("fe_valid", rxValid, 0);
        step(1'b0);
        check("fe_pulse_end", frameErr, 0);
        for (int i = 0; i < 6; i++) step(1'b0);
        idle(16);
        check("fe_count", n_ferr - b_ferr, 1);
        check("fe_data_kept", rxData, 8'hA5);
        send(8'h11, 1'b1, 160);
        idle(4);
        check("fe_next_cnt", n_vrise - b_vrise, 1);
        check("fe_next_data", cap1, 8'h11);

        snap();
        rxReady = 1'b0;
        send(8'h12, 1'b1, 160);
        idle(4);
        check("ov_first_valid", rxValid, 1);
        check("ov_first_data", rxData, 8'h12);
        send(8'h34, 1'b1, 152);
        step(1'b1);
        check("ov_pulse", overrun, 1);
        check("ov_data_kept", rxData, 8'h12);
        check("ov_valid_held", rxValid, 1);
        step(1'b1);
        check("ov_pulse_end", overrun, 0);
        idle(6);
        check("ov_count", n_ovr - b_ovr, 1);
        check("ov_valid_wait", rxValid, 1);
        rxReady = 1'b1;
        step(1'b1);
        check("ov_consumed", rxValid, 0);

        snap();
        send(8'hF0, 1'b1, 72);
        check("rs_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("rs_busy", busy, 0);
        check("rs_data", rxData, 8'h00);
        check("rs_valid", rxValid, 0);
        check("rs_ferr", frameErr, 0);
        check("rs_ovr", overrun, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);
        send(8'h5A, 1'b1, 160);
        idle(4);
        check("rs_no_ferr", n_ferr - b_ferr, 0);
        check("rs_next_cnt", n_vrise - b_vrise, 1);
        check("rs_next_data", cap1, 8'h5A);

        snap();
        send(8'hFF, 1'b1, 160);
        idle(16);
        send(8'h00, 1'b1, 160);
        idle(4);
        check("bb_count", n_vrise - b_vrise, 2);
        check("bb_first", cap0, 8'hFF);
        check("bb_second", cap1, 8'h00);
        check("bb_no_ferr", n_ferr - b_ferr, 0);
        check("bb_no_ovr", n_ovr - b_ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
